// File: rtl/iter_cnt_pkg.sv
// Shared types and constants for the iteration counter.
//   state_e   : FSM encoding (IDLE / RUN / HOLD)
//   DEF_*     : default build parameters
//   PASS_W    : width of the optional completed-run counter
package iter_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int          DEF_WIDTH = 24;
  localparam int          DEF_STEP  = 4;
  localparam logic [23:0] DEF_LIMIT = 24'h3FF;
  localparam int          PASS_W    = 16;

endpackage

// File: rtl/sat_step_add.sv
// Combinational stride adder with clamp on carry-out.
//   a_i   : current count
//   sum_o : a_i + STEP, or all-ones if the WIDTH-bit sum overflows
module sat_step_add #(
  parameter int WIDTH = 24,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0] sum_ext;

  assign sum_ext = {1'b0, a_i} + STEP_EXT;
  // All-ones is >= any limit, so a clamped count terminates on the next step.
  assign sum_o   = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];

endmodule

// File: rtl/iter_counter_param.sv
// Iteration counter: steps by STEP up to a latched limit, then saturates
// (WRAP=0, parks in HOLD) or restarts from 0 (WRAP=1, stays in RUN).
//   aclk     : clock
//   aresetn  : synchronous reset, active HIGH despite the name
//   clr      : synchronous clear back to IDLE
//   start    : launch a run (accepted in IDLE/HOLD)
//   en       : count enable in RUN
//   limit    : terminal threshold, latched on accepted start
//   counter  : internal count delayed one cycle
//   ovf      : terminal-reached flag
//   done     : one-cycle pulse per termination
//   busy     : state == RUN
//   pass_cnt : completed-run count, present only with ITER_COUNTER_PASS_EN
module iter_counter_param
  import iter_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP,
  parameter int WRAP  = 0
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clr,
  input  logic              start,
  input  logic              en,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  counter,
  output logic              ovf,
  output logic              done,
`ifdef ITER_COUNTER_PASS_EN
  output logic [PASS_W-1:0] pass_cnt,
`endif
  output logic              busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [WIDTH-1:0]   counter_q;
  logic [WIDTH-1:0]   step_sum;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  sat_step_add #(.WIDTH(WIDTH), .STEP(STEP)) u_add (
    .a_i   (count_q),
    .sum_o (step_sum)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (start) begin
            limit_d = limit;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (en) begin
            if (count_q >= limit_q) begin
              ovf_d  = 1'b1;
              done_d = 1'b1;
              if (WRAP != 0) count_d = '0;
              else           state_d = HOLD;
            end else begin
              count_d = step_sum;
              ovf_d   = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      counter_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      counter_q <= count_q;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

`ifdef ITER_COUNTER_PASS_EN
  logic [PASS_W-1:0] pass_q, pass_d;

  // Counts on the same edge that raises done; start does not clear it.
  always_comb begin
    pass_d = pass_q + PASS_W'(done_d);
    if (clr) pass_d = '0;
  end

  always_ff @(posedge aclk) begin
    if (aresetn) pass_q <= '0;
    else         pass_q <= pass_d;
  end

  assign pass_cnt = pass_q;
`endif

  assign counter = counter_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign busy    = (state_q == RUN);

endmodule
